l2_writeback_buffer: RTL and testbench

Write-back buffer between the L2 cache and the RAM. Accepts evicted dirty lines from L2 and queues them in a small FIFO, then drains them into the RAM in the background. L2 miss fills therefore never wait behind a victim write. Reads from L2 are checked against the queued entries so that data not yet written to RAM is forwarded instead of stale RAM contents.

---
 rtl/l2_wb_pkg.sv | 26 ++
 rtl/l2_wb_fifo.sv | 104 ++++++++++
 rtl/l2_writeback_buffer.sv | 142 ++++++++++++++
 tb/tb_l2_writeback_buffer.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_wb_pkg.sv
// -----------------------------------------------------------------------------
// l2_wb_pkg
// Shared definitions for the L2 write-back buffer:
//   - drain_state_t : drain FSM states (IDLE, WRITE)
//   - DEF_*         : default address/data widths, FIFO depth and RAM latency
//   - count_width() : width of an occupancy counter that can hold 0..depth
// -----------------------------------------------------------------------------
package l2_wb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } drain_state_t;

    localparam int DEF_ADDR_WIDTH  = 8;
    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_DEPTH       = 4;
    localparam int DEF_RAM_LATENCY = 2;

    // One extra bit over the pointer width so that "full" (count == depth)
    // is representable.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/l2_wb_fifo.sv
// -----------------------------------------------------------------------------
// l2_wb_fifo
// Victim-line FIFO with an associative lookup port.
//   clk, reset               : clock, synchronous active-high reset
//   push, push_address/data  : append an entry at the tail (caller qualifies)
//   pop                      : drop the head entry (caller qualifies)
//   head_address/head_data   : oldest entry, the one being drained
//   lookup_address           : address compared against every valid entry
//   lookup_hit/lookup_data   : youngest matching entry; data is 0 on a miss
//   full, empty, count       : occupancy derived from the registered count
// -----------------------------------------------------------------------------
module l2_wb_fifo
    import l2_wb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic [ADDR_WIDTH-1:0]         push_address,
    input  logic [DATA_WIDTH-1:0]         push_data,
    input  logic                          pop,
    output logic [ADDR_WIDTH-1:0]         head_address,
    output logic [DATA_WIDTH-1:0]         head_data,
    input  logic [ADDR_WIDTH-1:0]         lookup_address,
    output logic                          lookup_hit,
    output logic [DATA_WIDTH-1:0]         lookup_data,
    output logic                          full,
    output logic                          empty,
    output logic [count_width(DEPTH)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = count_width(DEPTH);

    logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [DEPTH-1:0]      valid;
    logic [PTR_W-1:0]      head_ptr;
    logic [PTR_W-1:0]      tail_ptr;
    logic [CNT_W-1:0]      count_q;
    logic [PTR_W-1:0]      scan_idx;

    // NOTE: the storage arrays have no reset; valid bits and the count decide
    // which slots hold anything, so stale data after reset is never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail_ptr] <= push_address;
            data_mem[tail_ptr] <= push_data;
        end
    end

    // NOTE: state registers use non-blocking assignments so every update
    // sees pre-edge values, independent of statement order in the block.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid    <= '0;
            head_ptr <= '0;
            tail_ptr <= '0;
            count_q  <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (pop) begin
                valid[head_ptr] <= 1'b0;
                head_ptr        <= head_ptr + 1'b1;
            end
            if (push) begin
                valid[tail_ptr] <= 1'b1;
                tail_ptr        <= tail_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_address = addr_mem[head_ptr];
    assign head_data    = data_mem[head_ptr];
    assign count        = count_q;
    assign empty        = (count_q == '0);
    assign full         = (count_q == CNT_W'(DEPTH));

    // Scan from oldest (head) to youngest so a later match overrides an
    // earlier one: the youngest duplicate address wins.
    // NOTE: every output of this block is given a default before the loop,
    // so no path leaves a value held and no latch is inferred.
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        scan_idx    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head_ptr + PTR_W'(i);
            if (valid[scan_idx] && (addr_mem[scan_idx] == lookup_address)) begin
                lookup_hit  = 1'b1;
                lookup_data = data_mem[scan_idx];
            end
        end
    end

endmodule

// File: rtl/l2_writeback_buffer.sv
// -----------------------------------------------------------------------------
// l2_writeback_buffer
// Queues dirty victim lines from L2 and drains them to RAM in the background,
// forwarding queued data to L2 reads so stale RAM contents are never used.
//   clk, reset                  : clock, synchronous active-high reset
//   push_valid/address/data     : victim line from L2
//   push_ready                  : buffer accepts a push this cycle
//   lookup_address              : L2 read address to check
//   lookup_hit/lookup_data      : combinational forward of the youngest match
//   rd_pending                  : L2 fill in progress, holds off new drains
//   flush / flush_done          : drain-everything request / completion pulse
//   ram_write/address/dataIn    : RAM write port, held RAM_LATENCY cycles
//   empty, count                : occupancy
// -----------------------------------------------------------------------------
module l2_writeback_buffer
    import l2_wb_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int RAM_LATENCY = DEF_RAM_LATENCY
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push_valid,
    input  logic [ADDR_WIDTH-1:0]         push_address,
    input  logic [DATA_WIDTH-1:0]         push_data,
    output logic                          push_ready,
    input  logic [ADDR_WIDTH-1:0]         lookup_address,
    output logic                          lookup_hit,
    output logic [DATA_WIDTH-1:0]         lookup_data,
    input  logic                          rd_pending,
    input  logic                          flush,
    output logic                          flush_done,
    output logic                          ram_write,
    output logic [ADDR_WIDTH-1:0]         ram_address,
    output logic [DATA_WIDTH-1:0]         ram_dataIn,
    output logic                          empty,
    output logic [count_width(DEPTH)-1:0] count
);

    localparam int CNT_W = count_width(DEPTH);
    localparam int LAT_W = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RAM_LATENCY - 1);

    drain_state_t          state;
    drain_state_t          state_next;
    logic [LAT_W-1:0]      lat_cnt;
    logic [LAT_W-1:0]      lat_cnt_next;
    logic                  flushing;
    logic                  full;
    logic                  push_fire;
    logic                  pop;
    logic                  drain_ok;
    logic                  flush_complete;
    logic [ADDR_WIDTH-1:0] head_address;
    logic [DATA_WIDTH-1:0] head_data;

    // Registered state only: a pop this cycle does not open a slot for a push
    // in the same cycle.
    assign push_ready     = !full && !flushing;
    assign push_fire      = push_valid && push_ready;
    // A flush overrides the hold-off from an outstanding L2 fill.
    assign drain_ok       = !rd_pending || flushing;
    assign flush_complete = flushing && empty && (state == IDLE);
    assign flush_done     = flush_complete;

    l2_wb_fifo #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk            (clk),
        .reset          (reset),
        .push           (push_fire),
        .push_address   (push_address),
        .push_data      (push_data),
        .pop            (pop),
        .head_address   (head_address),
        .head_data      (head_data),
        .lookup_address (lookup_address),
        .lookup_hit     (lookup_hit),
        .lookup_data    (lookup_data),
        .full           (full),
        .empty          (empty),
        .count          (count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            lat_cnt  <= '0;
            flushing <= 1'b0;
        end else begin
            state   <= state_next;
            lat_cnt <= lat_cnt_next;
            // Completion takes priority; a flush request while already
            // flushing changes nothing.
            if (flush_complete)
                flushing <= 1'b0;
            else if (flush)
                flushing <= 1'b1;
        end
    end

    // An entry arriving on this edge counts as available, so a push into an
    // empty idle buffer starts its RAM write in the very next cycle.
    always_comb begin
        state_next   = state;
        lat_cnt_next = lat_cnt;
        pop          = 1'b0;
        ram_write    = 1'b0;
        ram_address  = '0;
        ram_dataIn   = '0;
        case (state)
            IDLE: begin
                if ((!empty || push_fire) && drain_ok) begin
                    state_next   = WRITE;
                    lat_cnt_next = LAT_LOAD;
                end
            end
            WRITE: begin
                ram_write   = 1'b1;
                ram_address = head_address;
                ram_dataIn  = head_data;
                if (lat_cnt == '0) begin
                    pop = 1'b1;
                    // Entries left after this pop: anything behind the head,
                    // plus a push landing on the same edge.
                    if (((count > CNT_W'(1)) || push_fire) && drain_ok)
                        lat_cnt_next = LAT_LOAD;
                    else
                        state_next = IDLE;
                end else begin
                    lat_cnt_next = lat_cnt - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_l2_writeback_buffer.sv
// -----------------------------------------------------------------------------
// tb_l2_writeback_buffer
// Self-checking bench: directed scenarios followed by random traffic, every
// cycle compared against a queue-based reference model of the buffer.
// -----------------------------------------------------------------------------
module tb_l2_writeback_buffer;
    import l2_wb_pkg::*;

    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int LAT   = 2;
    localparam int CW    = count_width(DEPTH);

    logic          clk = 1'b0;
    logic          reset;
    logic          push_valid;
    logic [AW-1:0] push_address;
    logic [DW-1:0] push_data;
    logic          push_ready;
    logic [AW-1:0] lookup_address;
    logic          lookup_hit;
    logic [DW-1:0] lookup_data;
    logic          rd_pending;
    logic          flush;
    logic          flush_done;
    logic          ram_write;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_dataIn;
    logic          empty;
    logic [CW-1:0] count;

    always #5 clk = ~clk;

    l2_writeback_buffer #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .DEPTH       (DEPTH),
        .RAM_LATENCY (LAT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .push_valid     (push_valid),
        .push_address   (push_address),
        .push_data      (push_data),
        .push_ready     (push_ready),
        .lookup_address (lookup_address),
        .lookup_hit     (lookup_hit),
        .lookup_data    (lookup_data),
        .rd_pending     (rd_pending),
        .flush          (flush),
        .flush_done     (flush_done),
        .ram_write      (ram_write),
        .ram_address    (ram_address),
        .ram_dataIn     (ram_dataIn),
        .empty          (empty),
        .count          (count)
    );

    // Reference model: queue of pending lines, cycles left in the current RAM
    // write (0 = not writing), and the flush request flag.
    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } entry_t;

    entry_t q[$];
    int     write_left = 0;
    bit     m_flushing = 0;

    logic [DW-1:0] dut_ram [256];
    int checks = 0;
    int errors = 0;
    int rw_seen = 0;
    int fd_seen = 0;
    bit check_en = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_model();
        logic          e_rw;
        logic [AW-1:0] e_ra;
        logic [DW-1:0] e_rd;
        logic          e_hit;
        logic [DW-1:0] e_ld;
        e_rw  = (write_left > 0);
        e_ra  = '0;
        e_rd  = '0;
        if (e_rw) begin
            e_ra = q[0].a;
            e_rd = q[0].d;
        end
        e_hit = 1'b0;
        e_ld  = '0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].a == lookup_address) begin
                e_hit = 1'b1;
                e_ld  = q[i].d;
                break;
            end
        end
        check("ram_write",   ram_write,   e_rw);
        check("ram_address", ram_address, e_ra);
        check("ram_dataIn",  ram_dataIn,  e_rd);
        check("push_ready",  push_ready,  (q.size() < DEPTH) && !m_flushing);
        check("count",       count,       q.size());
        check("empty",       empty,       q.size() == 0);
        check("lookup_hit",  lookup_hit,  e_hit);
        check("lookup_data", lookup_data, e_ld);
        check("flush_done",  flush_done,  m_flushing && q.size() == 0 && write_left == 0);
    endtask

    // Advances the model by one clock using the inputs sampled at the edge.
    task automatic model_step();
        bit fd;
        bit pr;
        bit go;
        if (reset) begin
            q.delete();
            write_left = 0;
            m_flushing = 0;
            return;
        end
        fd = m_flushing && q.size() == 0 && write_left == 0;
        pr = (q.size() < DEPTH) && !m_flushing;
        go = !rd_pending || m_flushing;
        if (write_left == 1)
            void'(q.pop_front());
        if (push_valid && pr)
            q.push_back('{a: push_address, d: push_data});
        if (write_left > 1)
            write_left--;
        else
            write_left = (q.size() > 0 && go) ? LAT : 0;
        if (fd)
            m_flushing = 0;
        else if (flush)
            m_flushing = 1;
    endtask

    // One clock: compare away from the edge, record RAM traffic, step model.
    task automatic tick();
        #1;
        if (check_en)
            compare_model();
        if (ram_write === 1'b1) begin
            dut_ram[ram_address] = ram_dataIn;
            rw_seen++;
        end
        if (flush_done === 1'b1)
            fd_seen++;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic push_one(input logic [AW-1:0] a, input logic [DW-1:0] d);
        push_valid   = 1'b1;
        push_address = a;
        push_data    = d;
        tick();
        push_valid   = 1'b0;
    endtask

    task automatic drain_wait();
        push_valid = 1'b0;
        flush      = 1'b0;
        rd_pending = 1'b0;
        for (int i = 0; i < 60 && !(q.size() == 0 && write_left == 0); i++)
            tick();
        tick();
        check("drained_empty", empty, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++)
            dut_ram[i] = '0;
        reset          = 1'b1;
        push_valid     = 1'b0;
        push_address   = '0;
        push_data      = '0;
        lookup_address = '0;
        rd_pending     = 1'b0;
        flush          = 1'b0;
        @(negedge clk);
        tick();
        check_en = 1;
        tick();
        reset = 1'b0;

        // Reset values.
        check("rst_push_ready", push_ready, 1'b1);
        check("rst_empty",      empty,      1'b1);
        check("rst_count",      count,      0);
        check("rst_ram_write",  ram_write,  1'b0);

        // Single push into an empty, idle buffer.
        rw_seen = 0;
        push_one(8'h12, 8'h5A);
        check("single_rw_first_cycle", ram_write, 1'b1);
        repeat (5) tick();
        check("single_rw_cycles", rw_seen, 2);
        check("single_ram_12",    dut_ram[8'h12], 8'h5A);
        check("single_empty",     empty, 1'b1);

        // Fill while an L2 fill is pending; fifth push bounces.
        rd_pending = 1'b1;
        rw_seen    = 0;
        push_one(8'h01, 8'hA1);
        push_one(8'h02, 8'hA2);
        push_one(8'h03, 8'hA3);
        push_one(8'h04, 8'hA4);
        push_one(8'h05, 8'hA5);
        check("fill_count",      count,      4);
        check("fill_push_ready", push_ready, 1'b0);
        check("fill_no_write",   rw_seen,    0);
        rd_pending = 1'b0;
        repeat (10) tick();
        check("fill_drain_cycles", rw_seen, 8);
        check("fill_ram_04",       dut_ram[8'h04], 8'hA4);
        check("fill_no_05",        dut_ram[8'h05], 8'h00);
        drain_wait();

        // Duplicate address: youngest wins; miss returns zero.
        rd_pending = 1'b1;
        push_one(8'h20, 8'h11);
        push_one(8'h20, 8'h22);
        lookup_address = 8'h20;
        #1;
        check("dup_hit",  lookup_hit,  1'b1);
        check("dup_data", lookup_data, 8'h22);
        lookup_address = 8'h21;
        #1;
        check("miss_hit",  lookup_hit,  1'b0);
        check("miss_data", lookup_data, 8'h00);
        drain_wait();

        // Full buffer: push during the popping cycle is refused, retry accepted.
        rd_pending = 1'b1;
        push_one(8'h40, 8'h01);
        push_one(8'h41, 8'h02);
        push_one(8'h42, 8'h03);
        push_one(8'h43, 8'h04);
        rd_pending = 1'b0;
        tick();
        tick();
        push_valid   = 1'b1;
        push_address = 8'h77;
        push_data    = 8'h99;
        #1;
        check("popcycle_push_ready", push_ready, 1'b0);
        tick();
        check("popcycle_count", count, 3);
        tick();
        push_valid = 1'b0;
        check("retry_count", count, 4);
        lookup_address = 8'h77;
        #1;
        check("retry_lookup", lookup_data, 8'h99);
        drain_wait();

        // Flush overrides rd_pending; one flush_done pulse.
        rd_pending = 1'b1;
        push_one(8'h50, 8'h05);
        push_one(8'h51, 8'h15);
        push_one(8'h52, 8'h25);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_push_ready", push_ready, 1'b0);
        fd_seen = 0;
        repeat (12) tick();
        check("flush_done_pulses", fd_seen, 1);
        check("flush_empty",       empty,   1'b1);
        check("flush_ram_52",      dut_ram[8'h52], 8'h25);
        rd_pending = 1'b0;

        // Flush of an already empty buffer completes on the next cycle.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        check("flush_empty_done", flush_done, 1'b1);
        tick();

        // Reset in the middle of a RAM write.
        push_one(8'h30, 8'h31);
        push_one(8'h32, 8'h33);
        check("midwrite_active", ram_write, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset_ram_write",  ram_write,  1'b0);
        check("midreset_count",      count,      0);
        check("midreset_empty",      empty,      1'b1);
        check("midreset_push_ready", push_ready, 1'b1);
        rw_seen = 0;
        repeat (4) tick();
        check("midreset_no_writes", rw_seen, 0);

        // Random traffic against the model.
        for (int n = 0; n < 800; n++) begin
            push_valid     = ($urandom_range(0, 2) != 0);
            push_address   = 8'h20 + 8'($urandom_range(0, 7));
            push_data      = 8'($urandom);
            lookup_address = 8'h20 + 8'($urandom_range(0, 7));
            rd_pending     = ($urandom_range(0, 3) == 0);
            flush          = ($urandom_range(0, 39) == 0);
            reset          = ($urandom_range(0, 249) == 0);
            tick();
        end
        reset = 1'b0;
        drain_wait();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
